// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the data-memory access stage: opcodes, FSM states
// and access-size decoding used by the load/store unit and its extractor.
package load_store_unit_pkg;

  localparam logic [5:0] OPCODE_LB  = 6'h20;
  localparam logic [5:0] OPCODE_LH  = 6'h21;
  localparam logic [5:0] OPCODE_LW  = 6'h23;
  localparam logic [5:0] OPCODE_LBU = 6'h24;
  localparam logic [5:0] OPCODE_LHU = 6'h25;
  localparam logic [5:0] OPCODE_SB  = 6'h28;
  localparam logic [5:0] OPCODE_SH  = 6'h29;
  localparam logic [5:0] OPCODE_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;

  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_NONE} access_size_t;

  // SIZE_NONE marks opcodes outside the load/store set; they fault like a misalignment.
  function automatic access_size_t op_size(logic [5:0] op);
    case (op)
      OPCODE_LB, OPCODE_LBU, OPCODE_SB: return SIZE_BYTE;
      OPCODE_LH, OPCODE_LHU, OPCODE_SH: return SIZE_HALF;
      OPCODE_LW, OPCODE_SW:             return SIZE_WORD;
      default:                          return SIZE_NONE;
    endcase
  endfunction

  function automatic logic op_is_store(logic [5:0] op);
    return (op == OPCODE_SB) || (op == OPCODE_SH) || (op == OPCODE_SW);
  endfunction

endpackage

// File: rtl/load_store_unit_load_extract.sv
// Selects the addressed byte/halfword/word from a read beat and applies
// sign or zero extension according to the load opcode.
module load_extract
  import load_store_unit_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] readdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result   = '0;
    byte_sel = readdata[8*ea_lo +: 8];
    half_sel = ea_lo[1] ? readdata[31:16] : readdata[15:0];
    case (opcode)
      OPCODE_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      OPCODE_LBU: result = {24'h0, byte_sel};
      OPCODE_LH:  result = {{16{half_sel[15]}}, half_sel};
      OPCODE_LHU: result = {16'h0, half_sel};
      OPCODE_LW:  result = readdata;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage of the multi-cycle core: forms base+offset, runs one Avalon-style
// transaction with waitrequest stalls and pulses done with the extended load value.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_result,
  output logic        misaligned,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata
);

  typedef struct packed {
    logic [5:0]  op;
    logic [1:0]  ea_lo;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] result;
    logic        fault;
  } lsu_regs_t;

  lsu_state_t   state_q, state_d;
  lsu_regs_t    r_q, r_d;
  logic [31:0]  ea;
  access_size_t size;
  logic         aligned;
  logic [31:0]  extracted;

  assign ea   = base + offset;
  assign size = op_size(opcode);

  always_comb begin
    aligned = 1'b0;
    case (size)
      SIZE_BYTE: aligned = 1'b1;
      SIZE_HALF: aligned = ~ea[0];
      SIZE_WORD: aligned = (ea[1:0] == 2'b00);
      default:   aligned = 1'b0;
    endcase
  end

  load_extract u_load_extract (
    .opcode   (r_q.op),
    .ea_lo    (r_q.ea_lo),
    .readdata (mem_readdata),
    .result   (extracted)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          r_d.op    = opcode;
          r_d.ea_lo = ea[1:0];
          if (!aligned) begin
            r_d.fault = 1'b1;
            state_d   = DONE;
          end else begin
            state_d       = REQ;
            r_d.address   = {ea[31:2], 2'b00};
            r_d.read      = ~op_is_store(opcode);
            r_d.write     = op_is_store(opcode);
            r_d.writedata = '0;
            case (size)
              SIZE_BYTE: begin
                r_d.byteenable = 4'b0001 << ea[1:0];
                r_d.writedata  = {4{store_data[7:0]}};
              end
              SIZE_HALF: begin
                r_d.byteenable = ea[1] ? 4'b1100 : 4'b0011;
                r_d.writedata  = {2{store_data[15:0]}};
              end
              default: begin
                r_d.byteenable = 4'b1111;
                r_d.writedata  = store_data;
              end
            endcase
            if (!op_is_store(opcode)) r_d.writedata = '0;
          end
        end
      end
      REQ: begin
        if (!mem_waitrequest) begin
          state_d        = DONE;
          r_d.read       = 1'b0;
          r_d.write      = 1'b0;
          r_d.address    = '0;
          r_d.byteenable = '0;
          r_d.writedata  = '0;
          if (r_q.read) r_d.result = extracted;
        end
      end
      DONE: begin
        state_d    = IDLE;
        r_d.result = '0;
        r_d.fault  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state and bus registers use non-blocking assignments and clear asynchronously,
  // so a mid-transaction reset drops the strobes without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign load_result    = r_q.result;
  assign misaligned     = r_q.fault;
  assign mem_address    = r_q.address;
  assign mem_read       = r_q.read;
  assign mem_write      = r_q.write;
  assign mem_byteenable = r_q.byteenable;
  assign mem_writedata  = r_q.writedata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: expected completions go
// to a scoreboard queue and are popped by a monitor whenever done pulses.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] base = '0, offset = '0, store_data = '0;
  logic        busy, done, misaligned, mem_read, mem_write;
  logic [31:0] load_result, mem_address, mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = '0;

  typedef struct {
    string       tag;
    logic [31:0] result;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   n_expected_done = 0;

  load_store_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .opcode          (opcode),
    .base            (base),
    .offset          (offset),
    .store_data      (store_data),
    .busy            (busy),
    .done            (done),
    .load_result     (load_result),
    .misaligned      (misaligned),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, "_sb_result"}, load_result, e.result);
        check({e.tag, "_sb_misaligned"}, {31'd0, misaligned}, {31'd0, e.fault});
      end
    end
  end

  // Drives one request at #1 after a rising edge and follows it to completion.
  task automatic do_txn(input string tag, input logic [5:0] op, input logic [31:0] b,
                        input logic [31:0] o, input logic [31:0] sd, input int waits,
                        input logic [31:0] rd, input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] res, input logic fault, input logic repulse);
    logic        is_st;
    logic [31:0] ea;
    exp_t        e;
    is_st = (op == OPCODE_SB) || (op == OPCODE_SH) || (op == OPCODE_SW);
    ea    = b + o;
    start = 1'b1; opcode = op; base = b; offset = o; store_data = sd;
    e.tag = tag; e.result = res; e.fault = fault;
    sb_q.push_back(e);
    n_expected_done++;
    @(posedge clk); #1;
    start = 1'b0; opcode = 6'($urandom); base = $urandom; offset = $urandom; store_data = $urandom;
    if (fault) begin
      check({tag, "_fault_done"}, {31'd0, done}, 32'd1);
      check({tag, "_fault_mis"}, {31'd0, misaligned}, 32'd1);
      check({tag, "_fault_strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
      check({tag, "_fault_result"}, load_result, 32'd0);
    end else begin
      for (int i = 0; i <= waits; i++) begin
        check({tag, "_read"}, {31'd0, mem_read}, {31'd0, ~is_st});
        check({tag, "_write"}, {31'd0, mem_write}, {31'd0, is_st});
        check({tag, "_addr"}, mem_address, {ea[31:2], 2'b00});
        check({tag, "_be"}, {28'd0, mem_byteenable}, {28'd0, be});
        if (is_st) check({tag, "_wdata"}, mem_writedata, wd);
        check({tag, "_no_early_done"}, {31'd0, done}, 32'd0);
        mem_waitrequest = (i < waits);
        mem_readdata    = (i < waits) ? $urandom : rd;
        start           = repulse && (i == 1);
        @(posedge clk); #1;
      end
      start = 1'b0;
      mem_waitrequest = 1'b0;
      mem_readdata    = $urandom;
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_done_strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
      check({tag, "_done_result"}, load_result, res);
      check({tag, "_done_mis"}, {31'd0, misaligned}, 32'd0);
    end
    @(posedge clk); #1;
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_result"}, load_result, 32'd0);
  endtask

  initial begin
    #3;
    check("reset_status", {28'd0, busy, done, misaligned, mem_read}, 32'd0);
    check("reset_write", {31'd0, mem_write}, 32'd0);
    check("reset_addr", mem_address, 32'd0);
    check("reset_be", {28'd0, mem_byteenable}, 32'd0);
    check("reset_wdata", mem_writedata, 32'd0);
    check("reset_result", load_result, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    //     tag          op          base          offset        store_data    w  readdata      be       wdata         result        flt rep
    do_txn("lw",        OPCODE_LW,  32'h00001000, 32'h00000004, 32'h0,        0, 32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0);
    do_txn("lb",        OPCODE_LB,  32'h00001000, 32'h00000003, 32'h0,        0, 32'h80112233, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 0);
    do_txn("lbu",       OPCODE_LBU, 32'h00001000, 32'h00000003, 32'h0,        0, 32'h80112233, 4'b1000, 32'h0,        32'h00000080, 0, 0);
    do_txn("sh",        OPCODE_SH,  32'h00002000, 32'h00000002, 32'h0000ABCD, 3, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0,        0, 0);
    do_txn("lw_mis",    OPCODE_LW,  32'h00001000, 32'hFFFFFFFE, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);
    do_txn("lh_repulse",OPCODE_LH,  32'h00003000, 32'h00000002, 32'h0,        2, 32'h80017FFF, 4'b1100, 32'h0,        32'hFFFF8001, 0, 1);
    do_txn("lhu",       OPCODE_LHU, 32'h00003000, 32'h00000000, 32'h0,        1, 32'h8001F00F, 4'b0011, 32'h0,        32'h0000F00F, 0, 0);
    do_txn("sb",        OPCODE_SB,  32'h00004000, 32'h00000001, 32'h123456A5, 0, 32'h0,        4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0);
    do_txn("sw",        OPCODE_SW,  32'h00005000, 32'h00000000, 32'hCAFEF00D, 2, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0,        0, 0);
    do_txn("lh_mis",    OPCODE_LH,  32'h00003000, 32'h00000001, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);
    do_txn("sw_mis",    OPCODE_SW,  32'h00005000, 32'h00000002, 32'h11111111, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);
    do_txn("bad_op",    6'h3F,      32'h00005000, 32'h00000000, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);
    do_txn("lw_wrap",   OPCODE_LW,  32'hFFFFFFFC, 32'h00000008, 32'h0,        0, 32'h01234567, 4'b1111, 32'h0,        32'h01234567, 0, 0);

    // Abandoned transaction: reset while stalled must drop the strobe and never pulse done.
    start = 1'b1; opcode = OPCODE_LW; base = 32'h00006000; offset = 32'h0;
    mem_waitrequest = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rst_req_read", {31'd0, mem_read}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_read_drop", {31'd0, mem_read}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mem_waitrequest = 1'b0;
    @(posedge clk); #1;
    check("rst_no_done_count", n_done, n_expected_done);
    do_txn("post_rst",  OPCODE_LBU, 32'h00007000, 32'h00000002, 32'h0,        1, 32'h00C30000, 4'b0100, 32'h0,        32'h000000C3, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 32'd0);
    check("done_count", n_done, n_expected_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
